// File: rtl/vec_pe_pkg.sv
`default_nettype none
// vec_pe_pkg: width helpers and pipeline sideband shared by the PE datapath blocks.
// Revision 1.0
package vec_pe_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic is_signed;
  } pe_sb_t;

  function automatic int f_depth(input int c);
    return (c <= 1) ? 0 : $clog2(c);
  endfunction

  function automatic int f_w_m(input int w_x, input int w_k);
    return w_x + w_k + 1;
  endfunction

  function automatic int f_w_t(input int w_m, input int c);
    return w_m + f_depth(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_mac_stream_if.sv
`default_nettype none
// vec_mac_stream_if: beat input stream and result output stream of the dot-product engine.
// Revision 1.0
interface vec_mac_stream_if #(
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int W_EXT = 8,
  parameter int W_CNT = 16
);
  import vec_pe_pkg::*;

  localparam int W_Y = f_w_t(f_w_m(W_X, W_K), C) + W_EXT;

  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic             s_signed;
  logic [C*W_X-1:0] s_x;
  logic [C*W_K-1:0] s_k;
  logic             m_valid;
  logic             m_ready;
  logic [W_Y-1:0]   m_y;
  logic [W_CNT-1:0] m_beats;

  modport master (
    output s_valid, s_last, s_signed, s_x, s_k, m_ready,
    input  s_ready, m_valid, m_y, m_beats
  );

  modport slave (
    input  s_valid, s_last, s_signed, s_x, s_k, m_ready,
    output s_ready, m_valid, m_y, m_beats
  );

endinterface
`default_nettype wire

// File: rtl/vec_adder_tree.sv
`default_nettype none
// vec_adder_tree: pipelined pairwise reduction of C_PAD signed products, one level per register.
// Revision 1.0
module vec_adder_tree
  import vec_pe_pkg::*;
#(
  parameter int  C_PAD = 8,
  parameter int  W_M   = 17,
  localparam int DEPTH = f_depth(C_PAD),
  localparam int W_T   = W_M + DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [C_PAD*W_M-1:0] data_i,
  input  pe_sb_t               sb_i,
  output logic [W_T-1:0]       data_o,
  output pe_sb_t               sb_o
);

  // Level l holds C_PAD>>l nodes, each one bit wider than its children.
  for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
    localparam int N  = C_PAD >> l;
    localparam int WL = W_M + l;

    logic [2*N*(WL-1)-1:0] src;
    pe_sb_t                src_sb;
    logic [N*WL-1:0]       sum_q;
    pe_sb_t                sb_q;

    if (l == 1) begin : g_head
      assign src    = data_i;
      assign src_sb = sb_i;
    end else begin : g_body
      assign src    = g_lvl[l-1].sum_q;
      assign src_sb = g_lvl[l-1].sb_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        sb_q  <= '0;
      end else if (en_i) begin
        for (int i = 0; i < N; i++) begin
          sum_q[i*WL +: WL] <= WL'($signed(src[2*i*(WL-1) +: WL-1]))
                             + WL'($signed(src[(2*i+1)*(WL-1) +: WL-1]));
        end
        sb_q <= src_sb;
      end
    end
  end

  if (DEPTH == 0) begin : g_bypass
    assign data_o = data_i;
    assign sb_o   = sb_i;
  end else begin : g_tree
    assign data_o = g_lvl[DEPTH].sum_q;
    assign sb_o   = g_lvl[DEPTH].sb_q;
  end

endmodule
`default_nettype wire

// File: rtl/vec_mac_stream.sv
`default_nettype none
// vec_mac_stream: streaming signed/unsigned dot-product engine with multi-beat accumulation.
// Revision 1.0
module vec_mac_stream
  import vec_pe_pkg::*;
#(
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int W_EXT = 8,
  parameter int W_CNT = 16
) (
  input logic             clk,
  input logic             rst,
  vec_mac_stream_if.slave bus
);

  localparam int DEPTH = f_depth(C);
  localparam int C_PAD = 1 << DEPTH;
  localparam int W_M   = f_w_m(W_X, W_K);
  localparam int W_T   = f_w_t(W_M, C);
  localparam int W_Y   = W_T + W_EXT;

  logic                 adv;
  logic [C_PAD*W_M-1:0] prod_d;
  logic [C_PAD*W_M-1:0] prod_q;
  pe_sb_t               sb_q;
  logic [W_T-1:0]       tree_y;
  pe_sb_t               tree_sb;
  logic [W_Y-1:0]       tree_ext;
  logic [W_Y-1:0]       sum_d;
  logic [W_Y-1:0]       acc_q;
  logic [W_Y-1:0]       m_y_q;
  logic [W_CNT-1:0]     cnt_d;
  logic [W_CNT-1:0]     cnt_q;
  logic [W_CNT-1:0]     m_beats_q;
  logic                 first_q;
  logic                 m_valid_q;

  // Whole pipeline freezes while a result is waiting on downstream.
  assign adv         = !m_valid_q || bus.m_ready;
  assign bus.s_ready = adv;

  for (genvar i = 0; i < C_PAD; i++) begin : g_lane
    if (i < C) begin : g_mul
      logic signed [W_X:0] x_ext;
      logic signed [W_K:0] k_ext;
      assign x_ext = {bus.s_signed & bus.s_x[i*W_X + W_X - 1], bus.s_x[i*W_X +: W_X]};
      assign k_ext = {bus.s_signed & bus.s_k[i*W_K + W_K - 1], bus.s_k[i*W_K +: W_K]};
      assign prod_d[i*W_M +: W_M] = W_M'(x_ext) * W_M'(k_ext);
    end else begin : g_pad
      assign prod_d[i*W_M +: W_M] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      sb_q   <= '0;
    end else if (adv) begin
      prod_q <= prod_d;
      sb_q   <= '{valid: bus.s_valid, last: bus.s_last, is_signed: bus.s_signed};
    end
  end

  vec_adder_tree #(
    .C_PAD (C_PAD),
    .W_M   (W_M)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .en_i   (adv),
    .data_i (prod_q),
    .sb_i   (sb_q),
    .data_o (tree_y),
    .sb_o   (tree_sb)
  );

  // An unsigned beat's tree sum never sets its top bit, so either extension is exact.
  always_comb begin
    tree_ext = tree_sb.is_signed ? W_Y'($signed(tree_y)) : W_Y'(tree_y);
    sum_d    = (first_q ? '0 : acc_q) + tree_ext;
    cnt_d    = first_q ? W_CNT'(1) : cnt_q + W_CNT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      m_valid_q <= 1'b0;
      m_y_q     <= '0;
      m_beats_q <= '0;
    end else if (adv) begin
      m_valid_q <= tree_sb.valid && tree_sb.last;
      if (tree_sb.valid) begin
        cnt_q <= cnt_d;
        if (tree_sb.last) begin
          m_y_q     <= sum_d;
          m_beats_q <= cnt_d;
          first_q   <= 1'b1;
        end else begin
          acc_q   <= sum_d;
          first_q <= 1'b0;
        end
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_y     = m_y_q;
  assign bus.m_beats = m_beats_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_mac_stream.sv
`default_nettype none
// tb_vec_mac_stream: scoreboard bench driving C=8, C=5 and C=1 instances of vec_mac_stream.
// Revision 1.0
module tb_vec_mac_stream;
  import vec_pe_pkg::*;

  typedef struct {
    longint y;
    int     beats;
    int     cyc;
    bit     lat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_mac_stream_if #(.C(8)) b8 ();
  vec_mac_stream_if #(.C(5)) b5 ();
  vec_mac_stream_if #(.C(1)) b1 ();

  vec_mac_stream #(.C(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  vec_mac_stream #(.C(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
  vec_mac_stream #(.C(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  res_t   exp8[$], exp5[$], exp1[$];
  res_t   obs8[$], obs5[$], obs1[$];
  int     rd[3];
  longint macc[3];
  int     mcnt[3];
  int     xa[8];
  int     ka[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b8.m_valid && b8.m_ready)
      obs8.push_back('{y: longint'($signed(b8.m_y)), beats: int'(b8.m_beats), cyc: cyc, lat: 1'b0});
    if (b5.m_valid && b5.m_ready)
      obs5.push_back('{y: longint'($signed(b5.m_y)), beats: int'(b5.m_beats), cyc: cyc, lat: 1'b0});
    if (b1.m_valid && b1.m_ready)
      obs1.push_back('{y: longint'($signed(b1.m_y)), beats: int'(b1.m_beats), cyc: cyc, lat: 1'b0});
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lanes(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 5 : 1;
  endfunction

  function automatic bit rdy(input int sel);
    case (sel)
      0:       return b8.s_ready;
      1:       return b5.s_ready;
      default: return b1.s_ready;
    endcase
  endfunction

  function automatic int avail(input int sel);
    case (sel)
      0:       return obs8.size() - rd[0];
      1:       return obs5.size() - rd[1];
      default: return obs1.size() - rd[2];
    endcase
  endfunction

  function automatic int exp_n(input int sel);
    case (sel)
      0:       return exp8.size();
      1:       return exp5.size();
      default: return exp1.size();
    endcase
  endfunction

  task automatic pop_exp(input int sel, output res_t e);
    case (sel)
      0:       e = exp8.pop_front();
      1:       e = exp5.pop_front();
      default: e = exp1.pop_front();
    endcase
  endtask

  task automatic pop_obs(input int sel, output res_t o);
    case (sel)
      0:       o = obs8[rd[0]];
      1:       o = obs5[rd[1]];
      default: o = obs1[rd[2]];
    endcase
    rd[sel]++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one beat from xa/ka, waits for acceptance and updates the reference model.
  task automatic send(input int sel, input bit last, input bit sgn, input bit lat);
    logic [63:0] xv;
    logic [63:0] kv;
    logic [7:0]  xb;
    logic [7:0]  kb;
    longint      bsum;
    int          acc_c;
    bit          ok;
    res_t        e;
    xv   = '0;
    kv   = '0;
    bsum = 0;
    for (int i = 0; i < lanes(sel); i++) begin
      xb = xa[i][7:0];
      kb = ka[i][7:0];
      xv[i*8 +: 8] = xb;
      kv[i*8 +: 8] = kb;
      if (sgn) bsum += longint'($signed(xb)) * longint'($signed(kb));
      else     bsum += longint'(xb) * longint'(kb);
    end
    case (sel)
      0: begin b8.s_valid = 1'b1; b8.s_last = last; b8.s_signed = sgn; b8.s_x = xv;        b8.s_k = kv;        end
      1: begin b5.s_valid = 1'b1; b5.s_last = last; b5.s_signed = sgn; b5.s_x = xv[39:0];  b5.s_k = kv[39:0];  end
      default: begin b1.s_valid = 1'b1; b1.s_last = last; b1.s_signed = sgn; b1.s_x = xv[7:0]; b1.s_k = kv[7:0]; end
    endcase
    ok    = 1'b0;
    acc_c = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        ok    = 1'b1;
        acc_c = cyc;
        break;
      end
    end
    chk("accept", longint'(ok), 1);
    @(posedge clk);
    #1;
    case (sel)
      0:       b8.s_valid = 1'b0;
      1:       b5.s_valid = 1'b0;
      default: b1.s_valid = 1'b0;
    endcase
    macc[sel] += bsum;
    mcnt[sel]++;
    if (last) begin
      e = '{y: macc[sel], beats: mcnt[sel], cyc: acc_c, lat: lat};
      case (sel)
        0:       exp8.push_back(e);
        1:       exp5.push_back(e);
        default: exp1.push_back(e);
      endcase
      macc[sel] = 0;
      mcnt[sel] = 0;
    end
  endtask

  task automatic drain(input int sel, input int lat_exp, input string nm);
    res_t e;
    res_t o;
    int   ne;
    int   no;
    for (int t = 0; t < 100; t++) begin
      if (avail(sel) >= exp_n(sel)) break;
      tick(1);
    end
    tick(3);
    ne = exp_n(sel);
    no = avail(sel);
    chk($sformatf("%s.count", nm), longint'(no), longint'(ne));
    for (int i = 0; i < ne; i++) begin
      pop_exp(sel, e);
      if (i < no) begin
        pop_obs(sel, o);
        chk($sformatf("%s[%0d].m_y", nm, i), o.y, e.y);
        chk($sformatf("%s[%0d].m_beats", nm, i), longint'(o.beats), longint'(e.beats));
        if (e.lat) chk($sformatf("%s[%0d].latency", nm, i), longint'(o.cyc - e.cyc), longint'(lat_exp));
      end
    end
    while (avail(sel) > 0) pop_obs(sel, o);
  endtask

  task automatic fill(input int xv, input int kv);
    for (int i = 0; i < 8; i++) begin
      xa[i] = xv;
      ka[i] = kv;
    end
  endtask

  initial begin
    bit ok;
    int nb;
    rst = 1'b1;
    b8.s_valid = 0; b8.s_last = 0; b8.s_signed = 0; b8.s_x = '0; b8.s_k = '0; b8.m_ready = 1;
    b5.s_valid = 0; b5.s_last = 0; b5.s_signed = 0; b5.s_x = '0; b5.s_k = '0; b5.m_ready = 1;
    b1.s_valid = 0; b1.s_last = 0; b1.s_signed = 0; b1.s_x = '0; b1.s_k = '0; b1.m_ready = 1;
    for (int s = 0; s < 3; s++) begin
      rd[s]   = 0;
      macc[s] = 0;
      mcnt[s] = 0;
    end
    tick(2);
    chk("reset.m_valid", longint'(b8.m_valid), 0);
    chk("reset.m_y", longint'(b8.m_y), 0);
    chk("reset.m_beats", longint'(b8.m_beats), 0);
    chk("reset.s_ready", longint'(b8.s_ready), 1);
    rst = 1'b0;
    tick(1);

    // Single signed beat: ones times lane index.
    for (int i = 0; i < 8; i++) begin
      xa[i] = 1;
      ka[i] = i;
    end
    send(0, 1, 1, 1);
    drain(0, 5, "ramp");

    fill(255, 255);
    send(0, 0, 0, 1);
    send(0, 0, 0, 1);
    send(0, 1, 0, 1);
    drain(0, 5, "u255x3");

    send(0, 0, 1, 1);
    send(0, 0, 1, 1);
    send(0, 1, 1, 1);
    drain(0, 5, "s255x3");

    fill(-128, -128);
    send(0, 1, 1, 1);
    fill(-128, 127);
    send(0, 1, 1, 1);
    fill(255, 255);
    send(0, 0, 1, 1);
    send(0, 1, 0, 1);
    drain(0, 5, "extremes");

    // Four single-beat packets against a stalled result port.
    b8.m_ready = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        xa[i] = p;
        ka[i] = i + 1;
      end
      send(0, 1, 1, 0);
    end
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (b8.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp.valid_seen", longint'(ok), 1);
    chk("bp.s_ready_low", longint'(b8.s_ready), 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("bp.hold_m_y", longint'($signed(b8.m_y)), 36);
      chk("bp.hold_m_beats", longint'(b8.m_beats), 1);
      chk("bp.hold_m_valid", longint'(b8.m_valid), 1);
      chk("bp.hold_s_ready", longint'(b8.s_ready), 0);
    end
    @(posedge clk);
    #1;
    b8.m_ready = 1'b1;
    drain(0, 5, "bp");

    // Partial packet discarded by reset.
    fill(1, 1);
    send(0, 0, 1, 1);
    send(0, 0, 1, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid.m_valid", longint'(b8.m_valid), 0);
    chk("rst_mid.m_y", longint'(b8.m_y), 0);
    chk("rst_mid.m_beats", longint'(b8.m_beats), 0);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      macc[s] = 0;
      mcnt[s] = 0;
    end
    tick(3);
    chk("post_rst.m_valid", longint'(b8.m_valid), 0);
    chk("post_rst.m_y", longint'(b8.m_y), 0);
    send(0, 1, 1, 1);
    drain(0, 5, "after_rst");

    // Randomised multi-beat packets with bubbles on the padded and depth-0 instances.
    for (int sel = 1; sel <= 2; sel++) begin
      for (int p = 0; p < 20; p++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          for (int i = 0; i < 8; i++) begin
            xa[i] = $urandom_range(0, 255);
            ka[i] = $urandom_range(0, 255);
          end
          send(sel, b == nb - 1, 1'($urandom_range(0, 1)), 1);
          tick($urandom_range(0, 2));
        end
      end
      drain(sel, (sel == 1) ? 5 : 2, (sel == 1) ? "c5" : "c1");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_mac_stream.md
Name: vec_mac_stream

Overview:
- Streaming, pipelined signed/unsigned dot-product engine for the Processing Element.
- Each accepted beat carries C lane pairs (x, k). Per-beat products are reduced by a registered adder tree, then accumulated across beats until a beat flagged last.
- Emits one dot product per packet over a valid/ready handshake with full backpressure.
- Packet length is unbounded, so dot products longer than C lanes need no external accumulation.

Parameters:
- C, 8: lanes per beat (any value ≥1; padded internally to 2**$clog2(C)).
- W_X, 8: x operand width.
- W_K, 8: k operand width.
- W_EXT, 8: extra accumulator guard bits for multi-beat sums.
- W_CNT, 16: beat-counter width.
- Derived localparams:
  - DEPTH = $clog2(C)
  - W_M = W_X+W_K+1
  - W_T = W_M+DEPTH
  - W_Y = W_T+W_EXT
  - LAT = DEPTH+2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  engine can accept beat
- s_last  in  1  beat ends current dot product
- s_signed  in  1  1: operands signed; 0: operands unsigned (per beat)
- s_x  in  C*W_X  packed x lanes, lane 0 in LSBs
- s_k  in  C*W_K  packed k lanes
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_y  out  W_Y  signed dot-product result
- m_beats  out  W_CNT  number of beats in the reported dot product

Behaviour:
- Reset: one clk with rst=1 clears the following, discarding any in-flight packet:
  - all stage valid bits
  - accumulator
  - beat counter
  - first-beat flag set to 1
  - m_valid=0, m_y=0, m_beats=0
- Reset has priority over every other event.
- Global stall: adv = !m_valid || m_ready. s_ready = adv (combinational). Every pipeline register (data, valid, last, signed) updates only when adv=1. There is no bubble collapsing.
- Operand extension: each lane is extended to W+1 bits, sign-extended if s_signed else zero-extended, then multiplied signed into W_M bits. Unsigned max 255*255 = 65025 fits exactly.
- Stage 0 (accept edge): registers C_PAD products. Padded lanes produce 0.
- Stages 1..DEPTH: pairwise add; each stage width grows by 1 bit. The tree output is W_T bits.
- Accumulate stage, on an advancing edge with a valid tree output:
  - sum = (first ? 0 : acc) + sign-extended tree output, computed modulo 2**W_Y (wraps; no saturation).
  - cnt = (first ? 1 : cnt+1), wrapping at 2**W_CNT.
  - If last=1: m_y<=sum, m_beats<=cnt, m_valid<=1, first<=1.
  - If last=0: acc<=sum, first<=0.
- Latency: a last beat accepted in cycle n gives m_valid=1 in cycle n+LAT (5 for C=8; 2 for C=1).
- Throughput: 1 beat/cycle while m_ready=1. A single-beat packet (s_last on every beat) yields 1 result/cycle.
- Result handshake: m_valid=1 && m_ready=1 consumes the result. If a new last beat reaches the accumulate stage on the same edge, m_valid stays 1 with the new data; otherwise m_valid<=0. m_y and m_beats hold stable while m_valid=1 && m_ready=0.
- Sign mode mixes freely between beats and packets; the flag travels with its beat.
- s_valid=0 beats insert bubbles, which leave acc, cnt and first untouched.
- Inputs are ignored while s_ready=0.

Decomposition:
- Package vec_pe_pkg holds:
  - width functions: f_w_m(W_X, W_K), f_w_t(W_M, C), f_depth(C)
  - typedef for the per-stage sideband struct {valid, last, is_signed}, shared with other PE blocks
- Sub-module vec_adder_tree: parametrised (C_PAD, W_M), pipelined, with en input, sideband passthrough, and DEPTH latency.
- vec_mac_stream instantiates vec_adder_tree and owns operand extension, the multiply stage, the accumulator, the counter and the handshake.

Test Plan:
- C=8, signed single beat, x=all 1, k=lanes 0..7, s_last=1, m_ready=1 → m_y=28, m_beats=1, m_valid 5 cycles after acceptance.
- Unsigned, x=k=255 all lanes, 3-beat packet → m_y=3*8*65025=1560600, m_beats=3. The same data with s_signed=1 → m_y=24.
- Signed extremes: x=-128, k=-128 all lanes, 1 beat → m_y=131072. x=-128, k=127 → m_y=-130048.
- Backpressure: hold m_ready=0 after the first result with 4 single-beat packets streaming. Expect:
  - s_ready drops the cycle m_valid rises
  - m_y stable
  - releasing m_ready delivers all 4 in order with no loss or duplication
- Reset mid-packet: 2 non-last beats of value 1, then rst for 1 cycle, then a 1-beat packet of x=k=1 → m_y=8, m_beats=1 (prior partial discarded). All outputs 0 during/after reset.
- C=5 (padding) and C=1 (DEPTH=0): random signed/unsigned multi-beat packets with bubbles vs a scoreboard model → exact match; latency 5 and 2 respectively.
